lcd_byte_transmitter: RTL and testbench

//  Responder side of the ALU LCD write handshake (iWrite/iData/oReady).

---
 rtl/lcd_byte_transmitter_pkg.sv | 37 +++
 rtl/lcd_byte_transmitter_if.sv | 10 +
 rtl/lcd_delay_counter.sv | 25 ++
 rtl/lcd_byte_transmitter.sv | 104 ++++++++++
 tb/tb_lcd_byte_transmitter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/lcd_byte_transmitter_pkg.sv
// Shared definitions for the LCD byte transmitter: FSM state encodings,
// HD44780 command codes, and phase-decoding helpers.
package lcd_byte_transmitter_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_HI_SETUP = 4'd1,
    ST_HI_PULSE = 4'd2,
    ST_HI_HOLD  = 4'd3,
    ST_GAP      = 4'd4,
    ST_LO_SETUP = 4'd5,
    ST_LO_PULSE = 4'd6,
    ST_LO_HOLD  = 4'd7,
    ST_WAIT     = 4'd8
  } lcd_state_t;

  localparam logic [7:0] LCD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_HOME  = 8'h02;

  // The controller decodes 0x02 and 0x03 both as return-home, and 0x00 is grouped with them.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
    return !rs && (b inside {8'h00, LCD_CLEAR, LCD_HOME, 8'h03});
  endfunction

  function automatic logic is_pulse(input lcd_state_t s);
    return (s == ST_HI_PULSE) || (s == ST_LO_PULSE);
  endfunction

  function automatic logic is_hi_phase(input lcd_state_t s);
    return s inside {ST_HI_SETUP, ST_HI_PULSE, ST_HI_HOLD, ST_GAP};
  endfunction

  function automatic logic is_lo_phase(input lcd_state_t s);
    return s inside {ST_LO_SETUP, ST_LO_PULSE, ST_LO_HOLD, ST_WAIT};
  endfunction

endpackage

// File: rtl/lcd_byte_transmitter_if.sv
// Write handshake between the ALU LCD instruction path and the byte transmitter.
interface lcd_byte_transmitter_if;
  logic       write;
  logic [7:0] data;
  logic       rs;
  logic       ready;

  modport master (output write, output data, output rs, input ready);
  modport slave  (input write, input data, input rs, output ready);
endinterface

// File: rtl/lcd_delay_counter.sv
// Loadable down counter that times each transmitter phase; it stops at zero.
module lcd_delay_counter #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= value;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign done = (count == '0);

endmodule

// File: rtl/lcd_byte_transmitter.sv
// Sends one byte to an HD44780 character LCD as two 4-bit nibbles,
// high nibble first, with the enable strobe timed by a phase counter.
module lcd_byte_transmitter #(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 12,
    parameter int HOLD_CYC  = 1,
    parameter int GAP_CYC   = 50,
    parameter int WAIT_CYC  = 2000,
    parameter int LONG_CYC  = 82000,
    parameter int CNT_W     = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    lcd_byte_transmitter_if.slave   bus,
    output logic                    lcd_e,
    output logic                    lcd_rs,
    output logic                    lcd_rw,
    output logic [3:0]              lcd_data
);

    import lcd_byte_transmitter_pkg::*;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_CYC - 1);

    lcd_state_t       state, state_next;
    logic [7:0]       byte_q, byte_next;
    logic             rs_q, rs_next;
    logic             accept, load, done;
    logic [CNT_W-1:0] load_value;

    lcd_delay_counter #(.CNT_W(CNT_W)) u_delay (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .value (load_value),
        .done  (done)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_value = '0;
        byte_next  = byte_q;
        rs_next    = rs_q;
        accept     = bus.write && bus.ready;
        case (state)
            ST_IDLE: if (accept) begin
                state_next = ST_HI_SETUP; load = 1'b1; load_value = SETUP_LD;
                byte_next  = bus.data;    rs_next = bus.rs;
            end
            ST_HI_SETUP: if (done) begin state_next = ST_HI_PULSE; load = 1'b1; load_value = PULSE_LD; end
            ST_HI_PULSE: if (done) begin state_next = ST_HI_HOLD;  load = 1'b1; load_value = HOLD_LD;  end
            ST_HI_HOLD:  if (done) begin state_next = ST_GAP;      load = 1'b1; load_value = GAP_LD;   end
            ST_GAP:      if (done) begin state_next = ST_LO_SETUP; load = 1'b1; load_value = SETUP_LD; end
            ST_LO_SETUP: if (done) begin state_next = ST_LO_PULSE; load = 1'b1; load_value = PULSE_LD; end
            ST_LO_PULSE: if (done) begin state_next = ST_LO_HOLD;  load = 1'b1; load_value = HOLD_LD;  end
            ST_LO_HOLD:  if (done) begin
                state_next = ST_WAIT; load = 1'b1;
                load_value = is_long_cmd(rs_q, byte_q) ? LONG_LD : WAIT_LD;
            end
            ST_WAIT:     if (done) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        byte_q <= byte_next;
        rs_q   <= rs_next;
    end

    // Pins are registered from the next state so E changes cleanly on the same edge as the phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ready <= 1'b1;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 4'h0;
        end else begin
            bus.ready <= (state_next == ST_IDLE);
            lcd_e     <= is_pulse(state_next);
            if (state_next != ST_IDLE)
                lcd_rs <= rs_next;
            if (is_hi_phase(state_next))
                lcd_data <= byte_next[7:4];
            else if (is_lo_phase(state_next))
                lcd_data <= byte_next[3:0];
        end
    end

    assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_byte_transmitter.sv
// Scoreboard bench for lcd_byte_transmitter; the long clear/home delay is
// shortened through its parameter to keep the run brief.
module tb_lcd_byte_transmitter;

    localparam int SETUP = 2;
    localparam int PULSE = 12;
    localparam int HOLD  = 1;
    localparam int GAP   = 50;
    localparam int WAITC = 2000;
    localparam int LONG  = 10000;
    localparam int BASE  = 2 * (SETUP + PULSE + HOLD) + GAP;
    localparam int LO_RISE = SETUP + PULSE + HOLD + GAP + SETUP;

    typedef struct {int rise; logic [3:0] nib; logic rs; int width;} pulse_t;
    typedef struct {int fall; int len;} rdy_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lcd_e, lcd_rs, lcd_rw;
    logic [3:0] lcd_data;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;
    pulse_t exp_p[$];
    rdy_t   exp_r[$];

    lcd_byte_transmitter_if bus();

    lcd_byte_transmitter #(
        .SETUP_CYC(SETUP), .PULSE_CYC(PULSE), .HOLD_CYC(HOLD), .GAP_CYC(GAP),
        .WAIT_CYC(WAITC), .LONG_CYC(LONG), .CNT_W(17)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Issues one write; abort_at > 0 means a reset will land that many edges after acceptance during LO_PULSE.
    task automatic send(input logic [7:0] d, input logic r, input bit keep, input int abort_at, output int t0);
        int n;
        int len;
        pulse_t p;
        rdy_t q;
        bus.data  = d;
        bus.rs    = r;
        bus.write = 1'b1;
        n = 0;
        while (bus.ready !== 1'b1 && n < 30000) begin
            @(negedge clk);
            n++;
        end
        if (bus.ready !== 1'b1) begin
            chk("accept_timeout", 0, 1);
            t0 = -1;
            bus.write = 1'b0;
            return;
        end
        t0  = cyc + 1;
        len = BASE + ((!r && d <= 8'h03) ? LONG : WAITC);
        p = '{rise: t0 + SETUP, nib: d[7:4], rs: r, width: PULSE};
        exp_p.push_back(p);
        p = '{rise: t0 + LO_RISE, nib: d[3:0], rs: r, width: (abort_at > 0) ? abort_at - LO_RISE : PULSE};
        exp_p.push_back(p);
        q = '{fall: t0, len: (abort_at > 0) ? abort_at : len};
        exp_r.push_back(q);
        @(posedge clk);
        #1;
        if (!keep) bus.write = 1'b0;
    endtask

    pulse_t cur_p;
    rdy_t   cur_r;
    bit have_p = 1'b0, have_r = 1'b0, stable = 1'b1;
    bit prev_e = 1'b0, prev_r = 1'b1;
    int wcnt = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (lcd_e && bus.ready) chk("e_high_while_idle", 1, 0);
            if (lcd_e && !prev_e) begin
                if (exp_p.size() == 0) begin
                    chk("e_pulse_unexpected", 1, 0);
                    have_p = 1'b0;
                end else begin
                    cur_p = exp_p.pop_front();
                    have_p = 1'b1;
                    chk("e_rise_cycle", cyc, cur_p.rise);
                    chk("pulse_nibble", int'(lcd_data), int'(cur_p.nib));
                    chk("pulse_rs", int'(lcd_rs), int'(cur_p.rs));
                    wcnt = 1;
                    stable = 1'b1;
                end
            end else if (lcd_e && prev_e) begin
                wcnt++;
                if (have_p && (lcd_data !== cur_p.nib || lcd_rs !== cur_p.rs)) stable = 1'b0;
            end else if (!lcd_e && prev_e && have_p) begin
                chk("e_width", wcnt, cur_p.width);
                chk("pulse_bus_stable", int'(stable), 1);
                have_p = 1'b0;
            end
            if (!bus.ready && prev_r) begin
                if (exp_r.size() == 0) begin
                    chk("ready_fall_unexpected", 1, 0);
                    have_r = 1'b0;
                end else begin
                    cur_r = exp_r.pop_front();
                    have_r = 1'b1;
                    chk("accept_cycle", cyc, cur_r.fall);
                end
            end else if (bus.ready && !prev_r && have_r) begin
                chk("ready_low_len", cyc - cur_r.fall, cur_r.len);
                have_r = 1'b0;
            end
            prev_e = lcd_e;
            prev_r = bus.ready;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_a, t_b, t_c;
        int n;
        bus.write = 1'b0;
        bus.data  = 8'h00;
        bus.rs    = 1'b0;

        // Reset held three cycles, then idle outputs with no write request
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_ready", int'(bus.ready), 1);
            chk("rst_e", int'(lcd_e), 0);
            chk("rst_rs", int'(lcd_rs), 0);
            chk("rst_rw", int'(lcd_rw), 0);
            chk("rst_data", int'(lcd_data), 0);
        end
        mon_en = 1'b1;

        // Character byte, then long and normal commands including boundaries
        send(8'h41, 1'b1, 1'b0, 0, t_a);
        send(8'h01, 1'b0, 1'b0, 0, t_a);
        send(8'h0C, 1'b0, 1'b0, 0, t_a);
        send(8'h03, 1'b0, 1'b0, 0, t_a);
        send(8'h04, 1'b0, 1'b0, 0, t_a);
        send(8'h02, 1'b1, 1'b0, 0, t_a);

        // Write requests during a transfer are ignored
        send(8'h41, 1'b1, 1'b0, 0, t_a);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            bus.write = ~bus.write;
            bus.data  = 8'hFF;
            bus.rs    = 1'b0;
        end
        send(8'hFF, 1'b1, 1'b0, 0, t_b);
        chk("queued_write_gap", t_b - t_a, BASE + WAITC + 1);

        // Reset lands five cycles into the low-nibble pulse
        send(8'h6A, 1'b1, 1'b0, LO_RISE + 5, t_a);
        n = 0;
        while (cyc < t_a + LO_RISE + 4 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_e", int'(lcd_e), 0);
        chk("midrst_ready", int'(bus.ready), 1);
        rst = 1'b0;
        send(8'h55, 1'b1, 1'b0, 0, t_a);

        // Back-to-back with write held high
        send(8'h30, 1'b1, 1'b1, 0, t_a);
        send(8'h31, 1'b1, 1'b1, 0, t_b);
        chk("b2b_gap_1", t_b - t_a, BASE + WAITC + 1);
        send(8'h32, 1'b1, 1'b1, 0, t_c);
        chk("b2b_gap_2", t_c - t_b, BASE + WAITC + 1);
        send(8'h33, 1'b1, 1'b0, 0, t_a);
        chk("b2b_gap_3", t_a - t_c, BASE + WAITC + 1);

        n = 0;
        while (!(bus.ready === 1'b1 && exp_p.size() == 0 && exp_r.size() == 0) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("pulse_queue_drained", exp_p.size(), 0);
        chk("ready_queue_drained", exp_r.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
